nibble_subtractor_serial: RTL and testbench



---
 rtl/nibble_subtractor_serial.sv | 101 ++++++++++
 tb/tb_nibble_subtractor_serial.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_subtractor_serial.sv
// Bit-serial 4-bit subtractor: latches A/B/BIN on START, resolves one bit per cycle LSB first.
// Optional macro NIBBLE_SUB_SAT_EN clamps D to zero when the final borrow is set.
module nibble_subtractor_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       BIN,
  input  logic       START,
  output logic [3:0] D,
  output logic       BOUT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       br_q, br_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] d_q, d_d;
  logic       bout_q, bout_d;

  logic a_bit, b_bit, d_bit, br_nx;

  assign a_bit = a_q[idx_q];
  assign b_bit = b_q[idx_q];
  assign d_bit = a_bit ^ b_bit ^ br_q;
  assign br_nx = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    d_d     = d_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          br_d    = BIN;
          idx_d   = 2'd0;
          acc_d   = 4'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        idx_d        = idx_q + 2'd1;
        br_d         = br_nx;
        acc_d[idx_q] = d_bit;
        if (idx_q == 2'd3) begin
          // Outputs change only here, so partial bits never reach D.
          d_d     = {d_bit, acc_q[2:0]};
`ifdef NIBBLE_SUB_SAT_EN
          if (br_nx) d_d = 4'h0;
`endif
          bout_d  = br_nx;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      br_q    <= 1'b0;
      idx_q   <= 2'd0;
      acc_q   <= 4'd0;
      d_q     <= 4'd0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  assign D    = d_q;
  assign BOUT = bout_q;
  assign BUSY = (state_q == SHIFT);
  assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_nibble_subtractor_serial.sv
// Scoreboard bench for nibble_subtractor_serial: driver pushes expected results, monitor checks on DONE.
module tb_nibble_subtractor_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A, B;
  logic       BIN, START;
  logic [3:0] D;
  logic       BOUT, BUSY, DONE;

  typedef struct {
    logic [3:0] d;
    logic       bout;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_run = 0;
  int   n_done = 0;

  nibble_subtractor_serial dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .BIN(BIN), .START(START),
    .D(D), .BOUT(BOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer subtraction of the latched operands.
  function automatic exp_t model(input int a, input int b, input int bin, input int c);
    exp_t e;
    int diff;
    diff   = a - b - bin;
    e.d    = 4'(diff & 15);
    e.bout = (diff < 0);
`ifdef NIBBLE_SUB_SAT_EN
    if (e.bout) e.d = 4'h0;
`endif
    e.cyc = c;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge where DONE should be visible.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin, input bit hold);
    START = 1'b1;
    A = a;
    B = b;
    BIN = bin;
    sb_q.push_back(model(a, b, bin, cyc + 5));
    $display("issue A=%0h B=%0h BIN=%0d hold=%0d at cycle %0d", a, b, bin, hold, cyc);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        START = hold;
        A = 4'($urandom_range(0, 15));
        B = 4'($urandom_range(0, 15));
        BIN = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (BUSY) busy_run++;
      if (DONE) begin
        n_done++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: DONE=1 with no pending result, expected DONE=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("result D=%0h BOUT=%0d (exp D=%0h BOUT=%0d) cycle %0d", D, BOUT, e.d, e.bout, cyc);
          chk("D", D, e.d);
          chk("BOUT", BOUT, e.bout);
          chk("done_latency", cyc, e.cyc);
          chk("busy_cycles", busy_run, 4);
          chk("busy_low_in_fin", BUSY, 0);
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    START = 1'b0;
    A = 4'd0;
    B = 4'd0;
    BIN = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_D", D, 0);
    chk("reset_BOUT", BOUT, 0);
    chk("reset_BUSY", BUSY, 0);
    chk("reset_DONE", DONE, 0);

    // Release and start on the very first edge after release.
    rst_n = 1'b1;
    do_op(4'd9, 4'd3, 1'b0, 1'b0);
    START = 1'b0;
    @(negedge clk);
    do_op(4'd3, 4'd9, 1'b0, 1'b0);
    START = 1'b0;
    repeat (2) @(negedge clk);
    do_op(4'd5, 4'd5, 1'b1, 1'b0);
    do_op(4'd0, 4'd0, 1'b0, 1'b0);
    do_op(4'hF, 4'h0, 1'b1, 1'b0);
    START = 1'b0;
    @(negedge clk);

    // START held continuously; operands scrambled during SHIFT.
    for (int i = 0; i < 4; i++) do_op(4'hF, 4'h1, 1'b0, 1'b1);
    START = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      START = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    START = 1'b0;
    wait_drain(20);
    chk("done_count", n_done, 49);

    // Abort: reset during the 2nd SHIFT cycle of a non-zero result.
    do_op(4'hF, 4'h1, 1'b0, 1'b0);
    START = 1'b0;
    @(negedge clk);
    START = 1'b1;
    A = 4'hC;
    B = 4'h2;
    BIN = 1'b0;
    sb_q.push_back(model(4'hC, 4'h2, 0, cyc + 5));
    @(negedge clk);
    START = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    $display("reset asserted mid-shift at cycle %0d", cyc);
    chk("abort_D", D, 0);
    chk("abort_BOUT", BOUT, 0);
    chk("abort_BUSY", BUSY, 0);
    chk("abort_DONE", DONE, 0);
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    do_op(4'd8, 4'd2, 1'b0, 1'b0);
    START = 1'b0;
    repeat (3) @(negedge clk);
    wait_drain(20);
    chk("done_count_final", n_done, 51);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
